// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit for the MEM stage of the 5-stage pipeline.
//
// Sits between the EX/MEM register and a data memory that may insert wait
// states. Stores are converted to byte-lane enables with replicated data, and
// loads are sign- or zero-extended from the addressed lane. The pipeline is
// held via stall until the memory access completes or is aborted.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   MEM_MemRead / MEM_MemWrite  load / store request (store wins if both)
//   MEM_MemOp[2:0]              000 w, 001 h, 010 hu, 011 b, 100 bu, 101-111 w
//   MEM_addr[31:0]              byte address
//   MEM_wdata[31:0]             store data
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   registered memory request
//   dm_ready, dm_rdata          memory completion and read data
//   stall                       freeze upstream pipeline registers
//   load_data, load_valid       registered extended load result + pulse
//   misalign, timeout           one-cycle exception pulses
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_MemOp,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        timeout
);

  // The counter only has to reach MAX_WAIT-1; the abort fires on that cycle.
  localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;

  logic             dm_req_q;
  logic             dm_we_q;
  logic [3:0]       dm_be_q;
  logic [29:0]      dm_addr_q;
  logic [31:0]      dm_wdata_q;
  logic [31:0]      load_data_q;
  logic             load_valid_q;
  logic             misalign_q;
  logic             timeout_q;
  logic [2:0]       op_q;
  logic [1:0]       lane_q;
  logic [WaitW-1:0] wait_cnt_q;

  // Request decode (only meaningful in StIdle)
  logic        req_any;
  logic        is_store;
  logic        size_word;
  logic        size_half;
  logic        aligned;
  logic        start;
  logic        mis_req;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        wait_last;

  always_comb begin
    req_any   = MEM_MemRead | MEM_MemWrite;
    is_store  = MEM_MemWrite;
    size_half = (MEM_MemOp == 3'b001) || (MEM_MemOp == 3'b010);
    size_word = (MEM_MemOp == 3'b000) || (MEM_MemOp >= 3'b101);

    if (size_word) begin
      aligned = (MEM_addr[1:0] == 2'b00);
    end else if (size_half) begin
      aligned = ~MEM_addr[0];
    end else begin
      aligned = 1'b1;
    end

    start   = req_any & aligned;
    mis_req = req_any & ~aligned;

    // Loads always fetch the whole word; the lane is picked on return.
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    if (is_store) begin
      if (size_word) begin
        req_be    = 4'b1111;
        req_wdata = MEM_wdata;
      end else if (size_half) begin
        req_be    = MEM_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{MEM_wdata[15:0]}};
      end else begin
        req_be    = 4'b0001 << MEM_addr[1:0];
        req_wdata = {4{MEM_wdata[7:0]}};
      end
    end
  end

  assign wait_last = (wait_cnt_q == WaitW'(MAX_WAIT - 1));

  function automatic logic [31:0] extend_load(input logic [2:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = {16'h0, h};
      3'b011:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h0, b};
      default: res = word;
    endcase
    return res;
  endfunction

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StAccess;
      end
      StAccess: begin
        if (dm_ready || wait_last) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. stall rises combinationally so the request is held this cycle.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:   stall = start;
        StAccess: stall = 1'b1;
        StDone:   stall = 1'b0;
        default:  stall = 1'b0;
      endcase
    end
  end

  // Request, result and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= 4'h0;
      dm_addr_q    <= 30'h0;
      dm_wdata_q   <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      op_q         <= 3'b000;
      lane_q       <= 2'b00;
      wait_cnt_q   <= '0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          misalign_q <= mis_req;
          if (start) begin
            dm_req_q   <= 1'b1;
            dm_we_q    <= is_store;
            dm_be_q    <= req_be;
            dm_addr_q  <= MEM_addr[31:2];
            dm_wdata_q <= req_wdata;
            op_q       <= MEM_MemOp;
            lane_q     <= MEM_addr[1:0];
            wait_cnt_q <= '0;
          end
        end
        StAccess: begin
          if (dm_ready) begin
            dm_req_q <= 1'b0;
            if (!dm_we_q) begin
              load_data_q  <= extend_load(op_q, lane_q, dm_rdata);
              load_valid_q <= 1'b1;
            end
          end else if (wait_last) begin
            dm_req_q    <= 1'b0;
            load_data_q <= 32'h0;
            timeout_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StDone: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_be      = dm_be_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int MaxWait = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [2:0]  MEM_MemOp;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_wdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference byte memory (model) and word memory behind the DUT's port.
  logic [7:0]  ref_bytes [64];
  logic [31:0] dut_mem   [16];

  mem_stage_lsu #(.MAX_WAIT(MaxWait)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_MemRead  (MEM_MemRead),
    .MEM_MemWrite (MEM_MemWrite),
    .MEM_MemOp    (MEM_MemOp),
    .MEM_addr     (MEM_addr),
    .MEM_wdata    (MEM_wdata),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_be        (dm_be),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ready     (dm_ready),
    .dm_rdata     (dm_rdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign     (misalign),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit op_word(input logic [2:0] op);
    return (op == 3'd0) || (op >= 3'd5);
  endfunction

  function automatic bit op_half(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2);
  endfunction

  function automatic bit is_aligned(input logic [2:0] op, input logic [31:0] a);
    if (op_word(op)) return (a % 4) == 0;
    if (op_half(op)) return (a % 2) == 0;
    return 1'b1;
  endfunction

  // Load value straight from the byte memory with integer sign handling.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    int a;
    int v;
    a = int'(addr[5:0]);
    if (op_word(op)) begin
      return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
    end
    if (op_half(op)) begin
      v = int'(ref_bytes[a]) + 256 * int'(ref_bytes[a+1]);
      if (op == 3'd1 && v >= 32768) v = v - 65536;
    end else begin
      v = int'(ref_bytes[a]);
      if (op == 3'd3 && v >= 128) v = v - 256;
    end
    return 32'(v);
  endfunction

  task automatic poke_word(input int idx, input logic [31:0] val);
    dut_mem[idx] = val;
    for (int i = 0; i < 4; i++) ref_bytes[4*idx+i] = val[8*i +: 8];
  endtask

  task automatic idle_inputs();
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    MEM_MemOp    = 3'd0;
    MEM_addr     = 32'h0;
    MEM_wdata    = 32'h0;
  endtask

  // One MEM-stage access. waits >= MaxWait means the memory never answers.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits);
    bit          st;
    bit          to;
    int          acc;
    int          stalls;
    int          a;
    logic [31:0] exp_ld;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    st = wr;
    a  = int'(addr[5:0]);
    @(negedge clk);
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemOp = op; MEM_addr = addr; MEM_wdata = wd;
    #1;
    if (!is_aligned(op, addr)) begin
      check("mis_stall", {31'h0, stall}, 32'd0);
      check("mis_req", {31'h0, dm_req}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("mis_pulse", {31'h0, misalign}, 32'd1);
      check("mis_req2", {31'h0, dm_req}, 32'd0);
      check("mis_stall2", {31'h0, stall}, 32'd0);
      @(negedge clk);
      #1;
      check("mis_clear", {31'h0, misalign}, 32'd0);
      return;
    end
    if (!st) begin
      exp_be = 4'hF; exp_wd = 32'h0;
    end else if (op_word(op)) begin
      exp_be = 4'hF; exp_wd = wd;
    end else if (op_half(op)) begin
      exp_be = 4'(3 << (a % 4)); exp_wd = {wd[15:0], wd[15:0]};
    end else begin
      exp_be = 4'(1 << (a % 4)); exp_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    end
    to     = (waits >= MaxWait);
    acc    = to ? MaxWait : waits + 1;
    exp_ld = to ? 32'h0 : model_load(op, addr);
    check("stall_idle", {31'h0, stall}, 32'd1);
    stalls = stall ? 1 : 0;
    for (int c = 0; c < acc; c++) begin
      @(negedge clk);
      // Junk on MEM_* while busy must be ignored.
      MEM_MemRead = 1'($urandom); MEM_MemWrite = 1'($urandom); MEM_MemOp = 3'($urandom);
      MEM_addr = $urandom; MEM_wdata = $urandom;
      #1;
      if (stall) stalls++;
      check("acc_stall", {31'h0, stall}, 32'd1);
      check("acc_req", {31'h0, dm_req}, 32'd1);
      check("acc_we", {31'h0, dm_we}, {31'h0, st});
      check("acc_be", {28'h0, dm_be}, {28'h0, exp_be});
      check("acc_addr", {2'b00, dm_addr}, {2'b00, addr[31:2]});
      if (st) check("acc_wdata", dm_wdata, exp_wd);
      if (!to && c == waits) begin
        dm_ready = 1'b1;
        dm_rdata = dut_mem[dm_addr[3:0]];
        if (dm_we) begin
          for (int i = 0; i < 4; i++)
            if (dm_be[i]) dut_mem[dm_addr[3:0]][8*i +: 8] = dm_wdata[8*i +: 8];
        end
      end else begin
        dm_ready = 1'b0;
        dm_rdata = $urandom;
      end
    end
    @(negedge clk);
    // DONE: a valid aligned request and a stray ready must both be ignored.
    dm_ready = 1'($urandom); dm_rdata = $urandom;
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'($urandom); MEM_MemOp = 3'd0; MEM_addr = 32'h8;
    #1;
    check("done_stall", {31'h0, stall}, 32'd0);
    check("done_req", {31'h0, dm_req}, 32'd0);
    check("done_lvalid", {31'h0, load_valid}, {31'h0, (!st && !to)});
    check("done_timeout", {31'h0, timeout}, {31'h0, to});
    if (!st || to) check("done_ldata", load_data, exp_ld);
    check("stall_cycles", 32'(stalls), 32'(acc + 1));
    if (st && !to) begin
      ref_bytes[a] = wd[7:0];
      if (op_half(op) || op_word(op)) ref_bytes[a+1] = wd[15:8];
      if (op_word(op)) begin
        ref_bytes[a+2] = wd[23:16];
        ref_bytes[a+3] = wd[31:24];
      end
    end
    @(negedge clk);
    idle_inputs();
    dm_ready = 1'b0;
    #1;
    check("post_req", {31'h0, dm_req}, 32'd0);
    check("post_lvalid", {31'h0, load_valid}, 32'd0);
    check("post_timeout", {31'h0, timeout}, 32'd0);
    check("post_stall", {31'h0, stall}, 32'd0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    int          r_wait;
    bit          r_rd;
    bit          r_wr;

    for (int i = 0; i < 16; i++) poke_word(i, $urandom);
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    rst = 1'b1;
    // Aligned request during reset must not raise stall.
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_MemOp = 3'd0;
    MEM_addr = 32'h4; MEM_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'h0, stall}, 32'd0);
    check("rst_req", {31'h0, dm_req}, 32'd0);
    check("rst_we", {31'h0, dm_we}, 32'd0);
    check("rst_be", {28'h0, dm_be}, 32'd0);
    check("rst_addr", {2'b00, dm_addr}, 32'd0);
    check("rst_wdata", dm_wdata, 32'd0);
    check("rst_ldata", load_data, 32'd0);
    check("rst_lvalid", {31'h0, load_valid}, 32'd0);
    check("rst_misalign", {31'h0, misalign}, 32'd0);
    check("rst_timeout", {31'h0, timeout}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    // Directed cases
    run_op(1'b0, 1'b1, 3'd0, 32'h4, 32'h12345678, 0);
    run_op(1'b0, 1'b1, 3'd3, 32'h7, 32'h000000AB, 1);
    run_op(1'b0, 1'b1, 3'd1, 32'h2, 32'h0000BEEF, 0);
    poke_word(0, 32'h0080FF00);
    run_op(1'b1, 1'b0, 3'd3, 32'h2, 32'h0, 0);
    check("lb_value", model_load(3'd3, 32'h2), 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'd4, 32'h2, 32'h0, 0);
    poke_word(0, 32'h80010000);
    run_op(1'b1, 1'b0, 3'd1, 32'h2, 32'h0, 3);
    check("lh_value", model_load(3'd1, 32'h2), 32'hFFFF8001);
    run_op(1'b1, 1'b0, 3'd2, 32'h2, 32'h0, 3);
    run_op(1'b1, 1'b0, 3'd0, 32'h6, 32'h0, 0);
    run_op(1'b0, 1'b1, 3'd1, 32'h3, 32'hCAFED00D, 0);
    run_op(1'b1, 1'b1, 3'd6, 32'h9, 32'hDEADBEEF, 0);
    run_op(1'b1, 1'b0, 3'd0, 32'h8, 32'h0, MaxWait + 5);
    run_op(1'b0, 1'b1, 3'd0, 32'hC, 32'h55AA55AA, MaxWait);
    run_op(1'b1, 1'b0, 3'd0, 32'hC, 32'h0, MaxWait - 2);

    // Reset in the middle of an access
    @(negedge clk);
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_MemOp = 3'd0; MEM_addr = 32'h10;
    @(negedge clk);
    #1;
    check("mid_req_before", {31'h0, dm_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_req_rst", {31'h0, dm_req}, 32'd0);
    check("mid_stall_rst", {31'h0, stall}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    check("mid_after_req", {31'h0, dm_req}, 32'd0);

    // Randomised accesses
    for (int n = 0; n < 80; n++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 59));
      r_rd   = 1'($urandom);
      r_wr   = 1'($urandom);
      if (!r_rd && !r_wr) r_rd = 1'b1;
      r_wait = ($urandom_range(0, 9) == 0) ? MaxWait + 1 : $urandom_range(0, 4);
      run_op(r_rd, r_wr, r_op, r_addr, $urandom, r_wait);
    end

    // Memory contents must match the byte-level model
    for (int i = 0; i < 16; i++)
      check("mem_word", dut_mem[i],
            {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
